sha256_core_arbiter: RTL
========================

// Module: sha256_core_arbiter
// PURPOSE
//   Shares the single SHA-256 compression core among NREQ hash requesters:
//   gen_message_random, hash_message, fors_sign and wots_sign/treehash.
//   Round-robin arbitration happens only at hash-session boundaries. Once
//   granted, a requester owns the core for every block up to its final block.
//   Block fields are registered at issue, so a requester may change them after
//   ack. The core digest is returned to the owner with a one-hot done strobe.
// PARAMETERS
//   NREQ      4    number of requesters (index 0..NREQ-1)
//   IDX_W     2    width of requester index, clog2(NREQ)
//   HOLD_TMO  255  max cycles in S_HOLD waiting for the owner's next block
// PORTS
//   clk          in   1           clock
//   rstn         in   1           synchronous active-low reset
//   req          in   NREQ        per-requester block request; level, held until ack
//   req_1st      in   NREQ        block is first of a session (core loads IV/state)
//   req_seed     in   NREQ        block uses the pre-hashed seed state
//   req_final    in   NREQ        block is last of session; releases grant after done
//   req_state    in   NREQ*256    chaining state, requester k at [k*256+:256]
//   req_data     in   NREQ*512    message block, requester k at [k*512+:512]
//   req_len      in   NREQ*7      byte length, requester k at [k*7+:7]
//   ack          out  NREQ        one-hot 1-cycle pulse: block accepted (registered)
//   done         out  NREQ        one-hot 1-cycle pulse: digest valid on dout
//   dout         out  256         core digest, passthrough of core_dout
//   owner        out  IDX_W       current/last grant index
//   busy         out  1           high in any state other than S_IDLE
//   tmo_err      out  1           1-cycle pulse when S_HOLD timeout releases grant
//   sha256_start out  1           1-cycle start to core
//   sha256_1st   out  1           registered req_1st of owner
//   sha256_seed  out  1           registered req_seed of owner
//   sha256_final out  1           registered req_final of owner
//   sha256_state out  256         registered state of owner
//   sha256_din   out  512         registered data of owner
//   sha256_len   out  7           registered len of owner
//   core_done    in   1           core 1-cycle completion pulse
//   core_dout    in   256         core digest
// BEHAVIOUR
//   Reset: state S_IDLE. Pointer rr_ptr=0, owner=0, timeout counter=0.
//     All outputs are 0 except dout, which follows core_dout.
//   States:
//   - S_IDLE: if |req, winner = first set req at or after rr_ptr, wrapping.
//     Latch the winner's fields, owner<=winner, go to S_ISSUE.
//   - S_ISSUE (1 cycle): sha256_start=1, ack[owner]=1, go to S_WAIT.
//     sha256_* fields stay stable from S_ISSUE until leaving S_WAIT.
//   - S_WAIT: on core_done, done[owner]=1 in the same cycle.
//     If final is latched, go to S_IDLE and rr_ptr<=owner+1 (wraps NREQ-1->0).
//     Otherwise go to S_HOLD and clear the timeout counter.
//   - S_HOLD: only req[owner] is considered; other requests wait.
//     When it is set, latch the fields and go to S_ISSUE.
//     Otherwise the counter increments. At HOLD_TMO: tmo_err=1, rr_ptr<=owner+1,
//     go to S_IDLE.
//   Latency: req set at cycle t in S_IDLE -> sha256_start and ack at t+1.
//     core_done at t -> done at t (combinational).
//     Next block of the same session issues at earliest 2 cycles after done.
//   core_done outside S_WAIT is ignored; no done is produced.
//   A req deasserted before ack in S_IDLE: arbitration re-evaluates each cycle.
//     A req seen in the S_IDLE cycle is committed.
//   req_1st is forwarded as given; the arbiter does not enforce session order.
//   Reset mid-operation returns to S_IDLE. Core results arriving after reset
//     are dropped by the outside-S_WAIT rule.
// TESTING
//   1. Single requester 0: req with 1st=1 final=1 -> ack[0] at t+1, start=1,
//      din = req_data[511:0]. core_done -> done=4'b0001, back to S_IDLE.
//   2. req=4'b1111 after reset, each session 1 block -> grants in order 0,1,2,3.
//      rr_ptr wraps, next grant is 0.
//   3. Requester 2 runs a 3-block session while req[1] is held -> req[1] is not
//      acked until done[2] of the final block. 3 acks to 2, then ack[1].
//   4. Owner 3 is non-final and stops requesting; HOLD_TMO=4 -> tmo_err 1 cycle
//      after 4 S_HOLD cycles, then requester 0 is granted.
//   5. Change req_data[k] the cycle after ack -> sha256_din unchanged until done.
//   6. Stray core_done in S_IDLE -> done=0. rstn=0 in S_WAIT -> all outputs 0
//      the next cycle, state S_IDLE.

Source files
------------

// File: rtl/sha256_core_arbiter_if.sv
// Bundle of requester-side and core-side signals around the SHA-256 core arbiter.
// The slave modport is the arbiter; master is the environment (requesters plus core).
interface sha256_core_arbiter_if #(
   parameter int unsigned NREQ  = 4,
   parameter int unsigned IDX_W = 2
);
   logic [NREQ-1:0]     req;
   logic [NREQ-1:0]     req_1st;
   logic [NREQ-1:0]     req_seed;
   logic [NREQ-1:0]     req_final;
   logic [NREQ*256-1:0] req_state;
   logic [NREQ*512-1:0] req_data;
   logic [NREQ*7-1:0]   req_len;
   logic [NREQ-1:0]     ack;
   logic [NREQ-1:0]     done;
   logic [255:0]        dout;
   logic [IDX_W-1:0]    owner;
   logic                busy;
   logic                tmo_err;
   logic                sha256_start;
   logic                sha256_1st;
   logic                sha256_seed;
   logic                sha256_final;
   logic [255:0]        sha256_state;
   logic [511:0]        sha256_din;
   logic [6:0]          sha256_len;
   logic                core_done;
   logic [255:0]        core_dout;

   modport slave (
      input  req, req_1st, req_seed, req_final, req_state, req_data, req_len,
      input  core_done, core_dout,
      output ack, done, dout, owner, busy, tmo_err,
      output sha256_start, sha256_1st, sha256_seed, sha256_final,
      output sha256_state, sha256_din, sha256_len
   );

   modport master (
      output req, req_1st, req_seed, req_final, req_state, req_data, req_len,
      output core_done, core_dout,
      input  ack, done, dout, owner, busy, tmo_err,
      input  sha256_start, sha256_1st, sha256_seed, sha256_final,
      input  sha256_state, sha256_din, sha256_len
   );
endinterface

// File: rtl/sha256_core_arbiter.sv
// Session-granular round-robin arbiter sharing one SHA-256 compression core.
// A granted requester keeps the core until its final block completes or it times out.
module sha256_core_arbiter #(
   parameter int unsigned NREQ     = 4,
   parameter int unsigned IDX_W    = 2,
   parameter int unsigned HOLD_TMO = 255
) (
   input logic                  clk,
   input logic                  rstn,
   sha256_core_arbiter_if.slave bus
);
   localparam int unsigned CNT_W = $clog2(HOLD_TMO + 1);

   typedef enum logic [1:0] {StIdle, StIssue, StWait, StHold} state_e;

   state_e           state_q, state_d;
   logic [IDX_W-1:0] owner_q, owner_d;
   logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             first_q, seed_q, final_q;
   logic [255:0]     state_fld_q;
   logic [511:0]     din_q;
   logic [6:0]       len_q;

   logic             latch;
   logic [IDX_W-1:0] sel;
   logic [IDX_W-1:0] next_ptr;
   logic [IDX_W-1:0] cand;
   logic [IDX_W-1:0] winner;
   logic             win_found;
   logic [NREQ-1:0]  ack;
   logic [NREQ-1:0]  done;
   logic             tmo_err;

   assign next_ptr = (owner_q == IDX_W'(NREQ - 1)) ? '0 : owner_q + 1'b1;

   // First pending request at or after rr_ptr, wrapping.
   always_comb begin
      win_found = 1'b0;
      winner    = '0;
      cand      = '0;
      for (int i = 0; i < NREQ; i++) begin
         cand = IDX_W'((int'(rr_ptr_q) + i) % int'(NREQ));
         if (!win_found && bus.req[cand]) begin
            win_found = 1'b1;
            winner    = cand;
         end
      end
   end

   always_comb begin
      state_d  = state_q;
      owner_d  = owner_q;
      rr_ptr_d = rr_ptr_q;
      cnt_d    = cnt_q;
      latch    = 1'b0;
      sel      = owner_q;
      ack      = '0;
      done     = '0;
      tmo_err  = 1'b0;
      case (state_q)
         StIdle: begin
            if (win_found) begin
               latch   = 1'b1;
               sel     = winner;
               owner_d = winner;
               state_d = StIssue;
            end
         end
         StIssue: begin
            ack     = NREQ'(1) << owner_q;
            state_d = StWait;
         end
         StWait: begin
            if (bus.core_done) begin
               done = NREQ'(1) << owner_q;
               if (final_q) begin
                  rr_ptr_d = next_ptr;
                  state_d  = StIdle;
               end else begin
                  cnt_d   = '0;
                  state_d = StHold;
               end
            end
         end
         StHold: begin
            // Only the owner may continue; everyone else waits for the session to end.
            if (bus.req[owner_q]) begin
               latch   = 1'b1;
               state_d = StIssue;
            end else if (cnt_q == CNT_W'(HOLD_TMO)) begin
               tmo_err  = 1'b1;
               rr_ptr_d = next_ptr;
               state_d  = StIdle;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         state_q     <= StIdle;
         owner_q     <= '0;
         rr_ptr_q    <= '0;
         cnt_q       <= '0;
         first_q     <= 1'b0;
         seed_q      <= 1'b0;
         final_q     <= 1'b0;
         state_fld_q <= '0;
         din_q       <= '0;
         len_q       <= '0;
      end else begin
         state_q  <= state_d;
         owner_q  <= owner_d;
         rr_ptr_q <= rr_ptr_d;
         cnt_q    <= cnt_d;
         if (latch) begin
            first_q     <= bus.req_1st[sel];
            seed_q      <= bus.req_seed[sel];
            final_q     <= bus.req_final[sel];
            state_fld_q <= bus.req_state[sel*256 +: 256];
            din_q       <= bus.req_data[sel*512 +: 512];
            len_q       <= bus.req_len[sel*7 +: 7];
         end
      end
   end

   assign bus.ack          = ack;
   assign bus.done         = done;
   assign bus.dout         = bus.core_dout;
   assign bus.owner        = owner_q;
   assign bus.busy         = (state_q != StIdle);
   assign bus.tmo_err      = tmo_err;
   assign bus.sha256_start = (state_q == StIssue);
   assign bus.sha256_1st   = first_q;
   assign bus.sha256_seed  = seed_q;
   assign bus.sha256_final = final_q;
   assign bus.sha256_state = state_fld_q;
   assign bus.sha256_din   = din_q;
   assign bus.sha256_len   = len_q;
endmodule
